// File: rtl/alu_pkg.sv
// alu_pkg: opcode, FSM state and flag bit definitions shared by the sequential ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_CP,
    OP_INC, OP_DEC, OP_SLA, OP_SRA, OP_SRL, OP_RLC, OP_RRC, OP_RL
  } op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_H  = 4;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;
endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational adder/subtractor with carry/borrow, half-carry and overflow
module alu_addsub #(
  parameter int WIDTH = 8,
  parameter int HBIT = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             h,
  output logic             v
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0] full;
  logic cx;
  assign bx = sub ? ~b : b;
  assign cx = ci ^ sub;
  assign full = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(cx);
  assign sum = full[WIDTH-1:0];
  assign c = full[WIDTH] ^ sub;
  assign h = a[HBIT+1] ^ bx[HBIT+1] ^ sum[HBIT+1] ^ sub;
  assign v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked Z80-style ALU with flag generation and bit-serial shifts/rotates
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HBIT = 3,
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags
);
  state_e state_q, state_d;
  op_e op_i, op_q, op_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, result_q, result_d, as_b, as_sum, lg_r, step_v;
  logic [7:0] flags_q, flags_d;
  logic cy_q, cy_d, sub, as_ci, as_c, as_h, as_v, step_c;
  function automatic logic [7:0] mk_flags(logic [WIDTH-1:0] r, logic h, logic pv, logic n, logic c);
    return {r[WIDTH-1], ~|r, 1'b0, h, 1'b0, pv, n, c};
  endfunction
  function automatic logic [WIDTH:0] shift_step(op_e o, logic [WIDTH-1:0] v, logic cy);
    return o == OP_SLA ? {v[WIDTH-1], v[WIDTH-2:0], 1'b0}
         : o == OP_SRA ? {v[0], v[WIDTH-1], v[WIDTH-1:1]}
         : o == OP_SRL ? {v[0], 1'b0, v[WIDTH-1:1]}
         : o == OP_RLC ? {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]}
         : o == OP_RRC ? {v[0], v[0], v[WIDTH-1:1]}
         : {v[WIDTH-1], v[WIDTH-2:0], cy};
  endfunction
  assign op_i = op_e'(op);
  assign sub = op_i inside {OP_SUB, OP_SBC, OP_CP, OP_DEC};
  assign as_b = op_i inside {OP_INC, OP_DEC} ? WIDTH'(1) : b;
  assign as_ci = op_i inside {OP_ADC, OP_SBC} ? c_in : 1'b0;
  assign lg_r = op_i == OP_AND ? a & b : op_i == OP_OR ? a | b : a ^ b;
  assign {step_c, step_v} = shift_step(op_q, sh_q, cy_q);
  alu_addsub #(.WIDTH(WIDTH), .HBIT(HBIT)) u_addsub (
    .a(a), .b(as_b), .ci(as_ci), .sub(sub),
    .sum(as_sum), .c(as_c), .h(as_h), .v(as_v)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    cy_d = cy_q;
    result_d = result_q;
    flags_d = flags_q;
    if (flush) begin
      state_d = IDLE;
    end else if (state_q == IDLE && in_valid) begin
      state_d = DONE;
      if (op_i inside {OP_AND, OP_OR, OP_XOR}) begin
        result_d = lg_r;
        flags_d = mk_flags(lg_r, op_i == OP_AND, ~^lg_r, 1'b0, 1'b0);
      end else if (op_i >= OP_SLA && ~|b[SHW-1:0]) begin
        result_d = a;
        flags_d = mk_flags(a, 1'b0, ~^a, 1'b0, c_in);
      end else if (op_i >= OP_SLA) begin
        state_d = SHIFT;
        op_d = op_i;
        cnt_d = b[SHW-1:0];
        sh_d = a;
        cy_d = c_in;
      end else begin
        result_d = op_i == OP_CP ? a : as_sum;
        flags_d = mk_flags(as_sum, as_h, as_v, sub, op_i inside {OP_INC, OP_DEC} ? c_in : as_c);
      end
    end else if (state_q == SHIFT && ~|cnt_q) begin
      state_d = DONE;
      result_d = sh_q;
      flags_d = mk_flags(sh_q, 1'b0, ~^sh_q, 1'b0, cy_q);
    end else if (state_q == SHIFT) begin
      cnt_d = cnt_q - SHW'(1);
      sh_d = step_v;
      cy_d = step_c;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= OP_ADD;
      cnt_q <= '0;
      sh_q <= '0;
      cy_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      cy_q <= cy_d;
      result_q <= result_d;
      flags_q <= flags_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (8-bit and 16-bit builds)
module tb_alu_seq;
  import alu_pkg::*;
  typedef struct packed {logic [7:0] r; logic [7:0] f;} exp_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, c_in = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [3:0] op = 0;
  logic [7:0] a = 0, b = 0, result, flags;
  logic in_valid16 = 0, out_ready16 = 0, c16 = 0, in_ready16, out_valid16;
  logic [3:0] op16 = 0;
  logic [15:0] a16 = 0, b16 = 0, result16;
  logic [7:0] flags16;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );
  alu_seq #(.WIDTH(16), .HBIT(11)) dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .a(a16), .b(b16), .c_in(c16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flags(flags16)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input op_e o, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic [7:0] er, input logic [7:0] ef, input int elat);
    int lat = 0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op = o; a = av; b = bv; c_in = ci; in_valid = 1;
    @(posedge clk);
    sb.push_back('{r: er, f: ef});
    #1 in_valid = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 40);
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    e = sb.pop_front();
    chk({tag, "_res"}, 32'(result), 32'(e.r));
    chk({tag, "_flags"}, 32'(flags), 32'(e.f));
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int ov = 0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'(flags), 0);
    @(negedge clk) rst_n = 1;
    run_op("add", OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 1);
    run_op("sbc", OP_SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h93, 1);
    run_op("cp", OP_CP, 8'h42, 8'h42, 1'b0, 8'h42, 8'h42, 1);
    run_op("inc", OP_INC, 8'hFF, 8'h33, 1'b1, 8'h00, 8'h51, 1);
    run_op("rlc3", OP_RLC, 8'h81, 8'h03, 1'b0, 8'h0C, 8'h04, 4);
    run_op("srl0", OP_SRL, 8'h01, 8'h00, 1'b1, 8'h01, 8'h01, 1);
    run_op("dec", OP_DEC, 8'h80, 8'h00, 1'b0, 8'h7F, 8'h16, 1);
    run_op("sra2", OP_SRA, 8'h81, 8'h02, 1'b0, 8'hE0, 8'h80, 3);
    run_op("rl1", OP_RL, 8'h80, 8'h01, 1'b1, 8'h01, 8'h01, 2);
    run_op("sla2", OP_SLA, 8'h40, 8'h02, 1'b0, 8'h00, 8'h45, 3);
    run_op("rrc1", OP_RRC, 8'h01, 8'h01, 1'b0, 8'h80, 8'h81, 2);
    run_op("sub", OP_SUB, 8'h10, 8'h20, 1'b1, 8'hF0, 8'h83, 1);
    run_op("adc", OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, 1);
    run_op("or", OP_OR, 8'h00, 8'h00, 1'b1, 8'h00, 8'h44, 1);
    @(negedge clk);
    op = OP_AND; a = 8'hF0; b = 8'h3C; c_in = 1; in_valid = 1;
    @(posedge clk);
    sb.push_back('{r: 8'h30, f: 8'h14});
    #1 op = OP_ADD; a = 8'h01; b = 8'h01; c_in = 0;
    @(posedge clk);
    #1 chk("bp_valid", 32'(out_valid), 1);
    e = sb.pop_front();
    repeat (5) begin
      chk("bp_res", 32'(result), 32'(e.r));
      chk("bp_flags", 32'(flags), 32'(e.f));
      chk("bp_busy", 32'({out_valid, in_ready}), 32'b10);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    chk("bp_handshake", 32'({out_valid, in_ready}), 32'b01);
    @(posedge clk);
    sb.push_back('{r: 8'h02, f: 8'h00});
    #1 in_valid = 0;
    chk("bp_accept", 32'(in_ready), 0);
    @(posedge clk);
    #1 chk("bp2_valid", 32'(out_valid), 1);
    e = sb.pop_front();
    chk("bp2_res", 32'(result), 32'(e.r));
    chk("bp2_flags", 32'(flags), 32'(e.f));
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    run_op("xor", OP_XOR, 8'h55, 8'hAA, 1'b1, 8'hFF, 8'h84, 1);
    @(negedge clk);
    op = OP_SRA; a = 8'h80; b = 8'd7; c_in = 0; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (2) @(posedge clk);
    #1 chk("flush_busy", 32'(in_ready), 0);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("flush_idle", 32'({out_valid, in_ready}), 32'b01);
    chk("flush_res_kept", 32'(result), 32'hFF);
    chk("flush_flags_kept", 32'(flags), 32'h84);
    repeat (10) begin
      @(posedge clk);
      #1 ov += 32'(out_valid);
    end
    chk("flush_no_valid", 32'(ov), 0);
    @(negedge clk);
    op = OP_RLC; a = 8'h81; b = 8'd5; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_flags", 32'(flags), 0);
    @(negedge clk) rst_n = 1;
    run_op("rrc15", OP_RRC, 8'h01, 8'h0F, 1'b1, 8'h02, 8'h00, 16);
    @(negedge clk);
    op16 = OP_ADD; a16 = 16'h0FFF; b16 = 16'h0001; in_valid16 = 1;
    @(posedge clk);
    #1 in_valid16 = 0;
    @(posedge clk);
    #1 chk("add16_valid", 32'(out_valid16), 1);
    chk("add16_res", 32'(result16), 32'h1000);
    chk("add16_flags", 32'(flags16), 32'h10);
    out_ready16 = 1;
    @(posedge clk);
    #1 out_ready16 = 0;
    chk("add16_idle", 32'(in_ready16), 1);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
